// File: rtl/pio_input16_capture.sv
// pio_input16_capture: Avalon-MM input port with a two-flop synchronizer,
// an optional per-bit debouncer, sticky edge capture (write-1-to-clear)
// and a maskable, registered level interrupt. Read latency is one cycle.
`timescale 1ns/1ps
module pio_input16_capture #(
  parameter int WIDTH           = 16,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  // A zero-cycle debouncer still keeps a one-bit (always zero) counter so the
  // same flip rule covers both cases: a mismatch with cnt == max flips at once.
  localparam int            CW      = (DEBOUNCE_CYCLES == 0) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] capture_q, capture_d;
  logic [WIDTH-1:0] flip_s, event_s, clear_s;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;
  logic             rd_en_s, wr_en_s;

  // Per-bit debouncer: count consecutive mismatches, flip after max+1 of them.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = '0;
      if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = s2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Edge events from debounced flips, filtered by the configured direction.
  always_comb begin
    flip_s = stable_d ^ stable_q;
    if (EDGE_TYPE == 0) begin
      event_s = flip_s & stable_d;
    end else if (EDGE_TYPE == 1) begin
      event_s = flip_s & ~stable_d;
    end else begin
      event_s = flip_s;
    end
  end

  // Bus decode, capture/mask next state and interrupt condition.
  always_comb begin
    rd_en_s = chipselect & ~read_n;
    wr_en_s = chipselect & ~write_n;
    if (wr_en_s && (address == 2'd3)) begin
      clear_s = writedata[WIDTH-1:0];
    end else begin
      clear_s = '0;
    end
    if (wr_en_s && (address == 2'd2)) begin
      mask_d = writedata[WIDTH-1:0];
    end else begin
      mask_d = mask_q;
    end
    // set wins over a simultaneous clear on the same bit
    capture_d = (capture_q & ~clear_s) | event_s;
    irq_d     = |(capture_q & mask_q);
  end

  // Read mux: returns the pre-write register value; holds when not reading.
  always_comb begin
    readdata_d = readdata_q;
    if (rd_en_s) begin
      case (address)
        2'd0:    readdata_d = 32'(stable_q);
        2'd2:    readdata_d = 32'(mask_q);
        2'd3:    readdata_d = 32'(capture_q);
        default: readdata_d = 32'h0000_0000;
      endcase
    end else begin
      readdata_d = readdata_q;
    end
  end

  // State registers with synchronous reset; a reset drops any pending flip.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q       <= '0;
      s2_q       <= '0;
      stable_q   <= '0;
      mask_q     <= '0;
      capture_q  <= '0;
      readdata_q <= 32'h0000_0000;
      irq_q      <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q       <= in_port;
      s2_q       <= s1_q;
      stable_q   <= stable_d;
      mask_q     <= mask_d;
      capture_q  <= capture_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_pio_input16_capture.sv
// Bench for pio_input16_capture: three instances (rising/no debounce,
// any-edge/4-cycle debounce, falling/4-cycle debounce) share one bus and
// input; a reference model predicts readdata and irq of each every cycle.
`timescale 1ns/1ps
module tb_pio_input16_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect, read_n, write_n;
  logic [31:0] writedata;
  logic [15:0] in_port;
  logic [31:0] rdata [3];
  logic        irq_w [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pio_input16_capture #(.WIDTH(16), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(rdata[0]), .in_port(in_port), .irq(irq_w[0]));
  pio_input16_capture #(.WIDTH(16), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(4)) u_dut1 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(rdata[1]), .in_port(in_port), .irq(irq_w[1]));
  pio_input16_capture #(.WIDTH(16), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(4)) u_dut2 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(rdata[2]), .in_port(in_port), .irq(irq_w[2]));

  // Reference model state
  logic [15:0] hist [$];          // inputs sampled at the last two edges
  logic [15:0] m_stable [3];
  logic [15:0] m_mask   [3];
  logic [15:0] m_cap    [3];
  logic [31:0] m_rd     [3];
  logic        m_irq    [3];
  int          m_run    [3][16];  // consecutive samples differing from stable

  function automatic int db_of(input int j);
    return (j == 0) ? 0 : 4;
  endfunction

  function automatic int edge_of(input int j);
    return (j == 0) ? 0 : ((j == 1) ? 2 : 1);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock edge of the behavioural model, using the inputs held at the edge
  task automatic model_step();
    logic [15:0] samp, flip, st, ev, clr;
    samp = hist[0];
    for (int j = 0; j < 3; j++) begin
      if (reset) begin
        m_rd[j] = 32'h0; m_irq[j] = 1'b0; m_mask[j] = 16'h0;
        m_cap[j] = 16'h0; m_stable[j] = 16'h0;
        for (int b = 0; b < 16; b++) m_run[j][b] = 0;
      end else begin
        if (chipselect && !read_n) begin
          case (address)
            2'd0:    m_rd[j] = {16'h0, m_stable[j]};
            2'd2:    m_rd[j] = {16'h0, m_mask[j]};
            2'd3:    m_rd[j] = {16'h0, m_cap[j]};
            default: m_rd[j] = 32'h0;
          endcase
        end
        m_irq[j] = |(m_cap[j] & m_mask[j]);
        flip = 16'h0;
        for (int b = 0; b < 16; b++) begin
          if (samp[b] != m_stable[j][b]) begin
            m_run[j][b]++;
            if (m_run[j][b] > db_of(j)) begin
              flip[b] = 1'b1;
              m_run[j][b] = 0;
            end
          end else begin
            m_run[j][b] = 0;
          end
        end
        st = m_stable[j] ^ flip;
        if (edge_of(j) == 0) ev = flip & st;
        else if (edge_of(j) == 1) ev = flip & ~st;
        else ev = flip;
        clr = (chipselect && !write_n && address == 2'd3) ? writedata[15:0] : 16'h0;
        m_cap[j] = (m_cap[j] & ~clr) | ev;
        if (chipselect && !write_n && address == 2'd2) m_mask[j] = writedata[15:0];
        m_stable[j] = st;
      end
    end
    if (reset) begin
      hist = '{16'h0, 16'h0};
    end else begin
      void'(hist.pop_front());
      hist.push_back(in_port);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      check_eq($sformatf("readdata%0d", j), rdata[j], m_rd[j]);
      check_eq($sformatf("irq%0d", j), 32'(irq_w[j]), 32'(m_irq[j]));
    end
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_idle();
    chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
    address = 2'd0; writedata = 32'h0;
  endtask

  task automatic do_read(input logic [1:0] a);
    chipselect = 1'b1; read_n = 1'b0; address = a;
    tick();
    bus_idle();
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    bus_idle();
  endtask

  initial begin
    hist = '{16'h0, 16'h0};
    for (int j = 0; j < 3; j++) begin
      m_stable[j] = 16'h0; m_mask[j] = 16'h0; m_cap[j] = 16'h0;
      m_rd[j] = 32'h0; m_irq[j] = 1'b0;
      for (int b = 0; b < 16; b++) m_run[j][b] = 0;
    end
    reset = 1'b1; in_port = 16'h0; bus_idle();
    @(negedge clk);
    wait_n(3);
    reset = 1'b0;

    // reset state: all registers read 0, irq low
    for (int a = 0; a < 4; a++) begin
      do_read(2'(a));
      check_eq($sformatf("rst_read%0d", a), rdata[0], 32'h0);
    end
    check_eq("rst_irq", 32'(irq_w[0]), 32'h0);

    // rising edge on bit 0, no debounce: irq at edge k+4
    do_write(2'd2, 32'h0000_0001);
    in_port = 16'h0001;
    wait_n(3);
    check_eq("irq_k3", 32'(irq_w[0]), 32'h0);
    tick();
    check_eq("irq_k4", 32'(irq_w[0]), 32'h1);
    do_read(2'd0);
    check_eq("data_rise", rdata[0], 32'h0000_0001);
    do_read(2'd3);
    check_eq("cap_rise", rdata[0], 32'h0000_0001);
    wait_n(8);

    // write-1-to-clear: irq falls one edge after the write edge
    do_write(2'd3, 32'h0000_0001);
    check_eq("irq_clr_edge", 32'(irq_w[0]), 32'h1);
    tick();
    check_eq("irq_clr_after", 32'(irq_w[0]), 32'h0);

    // new event on the clear edge: set wins
    in_port = 16'h0000; wait_n(5);
    in_port = 16'h0001; wait_n(5);
    in_port = 16'h0000; wait_n(5);
    in_port = 16'h0001;
    wait_n(2);
    do_write(2'd3, 32'h0000_0001);
    check_eq("irq_coinc0", 32'(irq_w[0]), 32'h1);
    tick();
    check_eq("irq_coinc1", 32'(irq_w[0]), 32'h1);
    do_read(2'd3);
    check_eq("cap_coinc", rdata[0], 32'h0000_0001);
    wait_n(12);
    do_write(2'd3, 32'h0000_FFFF);

    // debounce: 3-cycle glitch on bit 5 is discarded
    in_port = 16'h0021; wait_n(3);
    in_port = 16'h0001; wait_n(12);
    do_read(2'd0);
    check_eq("glitch_data", rdata[1] & 32'h20, 32'h0);
    do_read(2'd3);
    check_eq("glitch_cap", rdata[1] & 32'h20, 32'h0);

    // debounce: 10-cycle pulse flips DATA bit 5 at edge k+7
    in_port = 16'h0021;
    wait_n(6);
    do_read(2'd0);
    check_eq("db_k7_pre", rdata[1] & 32'h20, 32'h0);
    do_read(2'd0);
    check_eq("db_k7_post", rdata[1] & 32'h20, 32'h20);
    wait_n(2);
    in_port = 16'h0001;
    wait_n(12);
    do_write(2'd3, 32'h0000_FFFF);

    // edge selection on bit 15: any-edge vs falling-only
    in_port = 16'h8001; wait_n(12);
    do_read(2'd3);
    check_eq("any_rise", rdata[1] & 32'h8000, 32'h8000);
    check_eq("fall_rise", rdata[2] & 32'h8000, 32'h0);
    do_write(2'd3, 32'h0000_FFFF);
    in_port = 16'h0001; wait_n(12);
    do_read(2'd3);
    check_eq("any_fall", rdata[1] & 32'h8000, 32'h8000);
    check_eq("fall_fall", rdata[2] & 32'h8000, 32'h8000);

    // randomized traffic checked against the model every cycle
    begin
      int hold;
      hold = 0;
      for (int c = 0; c < 600; c++) begin
        if (hold == 0) begin
          if ($urandom_range(0, 1) == 0) in_port = in_port ^ 16'($urandom_range(0, 65535));
          else in_port = in_port ^ (16'h1 << $urandom_range(0, 15));
          hold = $urandom_range(1, 8);
        end
        hold--;
        if ($urandom_range(0, 2) == 0) begin
          chipselect = 1'($urandom_range(0, 3) != 0);
          read_n     = 1'($urandom_range(0, 1));
          write_n    = 1'($urandom_range(0, 3) != 0);
          address    = 2'($urandom_range(0, 3));
          writedata  = $urandom;
        end else begin
          bus_idle();
        end
        tick();
      end
      bus_idle();
    end

    // reset while debounce counters are mid-count
    in_port = 16'h0000; wait_n(12);
    do_write(2'd2, 32'h0000_FFFF);
    in_port = 16'hFFFF;
    wait_n(4);
    reset = 1'b1; in_port = 16'h0000;
    wait_n(2);
    reset = 1'b0;
    for (int j = 0; j < 3; j++) check_eq($sformatf("mid_rst_irq%0d", j), 32'(irq_w[j]), 32'h0);
    wait_n(15);
    do_read(2'd0);
    check_eq("mid_rst_data", rdata[1], 32'h0);
    do_read(2'd2);
    check_eq("mid_rst_mask", rdata[1], 32'h0);
    do_read(2'd3);
    check_eq("mid_rst_cap", rdata[1], 32'h0);
    check_eq("mid_rst_irq_late", 32'(irq_w[1]), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
